// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter and the pipeline stages that
// talk to it: ownership encodings and bus data-size codes.
package bus_arbiter_pkg;

  // Bus ownership; also used as the "selected master" code, with OWN_IDLE
  // meaning no master is driving the bus.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } own_e;

  // One-hot transfer sizes shared with the Fetch and Memory stages.
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

endpackage : bus_arbiter_pkg

// File: rtl/bus_starve_ctr.sv
// Fetch starvation counter: counts consecutive cycles the fetch side is
// denied the bus, saturates at all-ones and flags when the limit is reached.
module bus_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_i,      // synchronous, active-high
  input  logic clr_i,      // clear has priority over increment
  input  logic inc_i,
  output logic starved_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= LIMIT_C);

endmodule : bus_starve_ctr

// File: rtl/bus_arbiter.sv
// Memory-bus arbiter between instruction fetch (I, read-only) and the Memory
// stage (D). D has default priority; a starvation counter forces I through
// at the next idle arbitration, and d_lock keeps the bus across a SWP pair.
// Grant is zero-latency: an idle bus forwards a request in the same cycle.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        Nrst,       // synchronous, active-high reset
  // fetch side
  input  logic [31:0] i_addr,
  input  logic        i_rd_req,
  output logic [31:0] i_rd_data,
  output logic        i_wait,
  // memory-stage side
  input  logic [31:0] d_addr,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [31:0] d_wr_data,
  input  logic [2:0]  d_size,
  input  logic        d_lock,
  output logic [31:0] d_rd_data,
  output logic        d_wait,
  // bus side
  output logic [31:0] busaddr,
  output logic        rd_req,
  output logic        wr_req,
  output logic [31:0] wr_data,
  output logic [2:0]  data_size,
  input  logic        rw_wait,
  input  logic [31:0] rd_data,
  // debug
  output logic [1:0]  owner
);

  own_e own_q;
  own_e own_d;
  own_e sel;
  logic d_req;
  logic sel_req;
  logic starved;
  logic cnt_clr;
  logic cnt_inc;

  assign d_req = d_rd_req | d_wr_req;

  // Select the master driving the bus this cycle; nobody while in reset.
  always_comb begin
    sel = OWN_IDLE;
    if (!Nrst) begin
      unique case (own_q)
        OWN_I:   sel = OWN_I;
        OWN_D:   sel = OWN_D;
        default: begin
          if (starved && i_rd_req) sel = OWN_I;
          else if (d_req)          sel = OWN_D;
          else if (i_rd_req)       sel = OWN_I;
        end
      endcase
    end
  end

  // Whether the selected master is actually asking for a transfer; an owner
  // that drops its request puts nothing on the bus and releases it.
  always_comb begin
    unique case (sel)
      OWN_I:   sel_req = i_rd_req;
      OWN_D:   sel_req = d_req;
      default: sel_req = 1'b0;
    endcase
  end

  // Route the selected master onto the bus; fetch is always a word read.
  always_comb begin
    busaddr   = 'x;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    wr_data   = 'x;
    data_size = 'x;
    unique case (sel)
      OWN_I: begin
        busaddr   = i_addr;
        rd_req    = i_rd_req;
        data_size = SIZE_WORD;
      end
      OWN_D: begin
        busaddr   = d_addr;
        rd_req    = d_rd_req;
        wr_req    = d_wr_req;
        wr_data   = d_wr_data;
        data_size = d_size;
      end
      default: ;
    endcase
  end

  // Stalls: the selected master follows the bus; the other stalls only if it
  // is asking. Both are held in reset.
  always_comb begin
    i_wait = 1'b1;
    d_wait = 1'b1;
    if (!Nrst) begin
      i_wait = (sel == OWN_I) ? rw_wait : i_rd_req;
      d_wait = (sel == OWN_D) ? rw_wait : d_req;
    end
  end

  // Next owner: hold while in flight, keep D across a locked completion,
  // otherwise release so the next cycle re-arbitrates.
  always_comb begin
    own_d = OWN_IDLE;
    if (sel_req && rw_wait) begin
      own_d = sel;
    end else if ((sel == OWN_D) && sel_req && d_lock) begin
      own_d = OWN_D;
    end
  end

  // Ownership register with synchronous reset.
  always_ff @(posedge clk) begin
    if (Nrst) begin
      own_q <= OWN_IDLE;
    end else begin
      own_q <= own_d;
    end
  end

  // Fetch denied while asking counts up; completion or no request clears.
  assign cnt_clr = !i_rd_req || ((sel == OWN_I) && !rw_wait);
  assign cnt_inc = i_rd_req && (sel != OWN_I);

  bus_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_i     (Nrst),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .starved_o (starved)
  );

  assign i_rd_data = rd_data;
  assign d_rd_data = rd_data;
  assign owner     = sel;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the arbiter.
module tb_bus_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] i_addr;
  logic        i_rd_req;
  logic [31:0] i_rd_data;
  logic        i_wait;
  logic [31:0] d_addr;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [31:0] d_wr_data;
  logic [2:0]  d_size;
  logic        d_lock;
  logic [31:0] d_rd_data;
  logic        d_wait;
  logic [31:0] busaddr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [2:0]  data_size;
  logic        rw_wait;
  logic [31:0] rd_data;
  logic [1:0]  owner;

  int passed = 0;
  int total  = 0;

  // Model state: who holds the bus (0 none, 1 I, 2 D) and the denial count.
  int m_own = 0;
  int m_cnt = 0;

  // Values sampled during the most recent cycle, for directed spot checks.
  logic [1:0]  s_owner;
  logic        s_wr_req;
  logic [31:0] s_wr_data;
  logic [31:0] s_busaddr;
  logic        s_rd_req;
  logic        s_i_wait;
  logic        s_d_wait;

  always #5 clk = ~clk;

  bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .i_addr    (i_addr),
    .i_rd_req  (i_rd_req),
    .i_rd_data (i_rd_data),
    .i_wait    (i_wait),
    .d_addr    (d_addr),
    .d_rd_req  (d_rd_req),
    .d_wr_req  (d_wr_req),
    .d_wr_data (d_wr_data),
    .d_size    (d_size),
    .d_lock    (d_lock),
    .d_rd_data (d_rd_data),
    .d_wait    (d_wait),
    .busaddr   (busaddr),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .data_size (data_size),
    .rw_wait   (rw_wait),
    .rd_data   (rd_data),
    .owner     (owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle: inputs are already applied; compare outputs against the
  // model mid-cycle, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    int  who;
    bit  dreq, wants, completes;
    int  nxt_own, nxt_cnt;
    #2;
    dreq = d_rd_req || d_wr_req;
    if (Nrst) begin
      who     = 0;
      nxt_own = 0;
      nxt_cnt = 0;
    end else begin
      if (m_own != 0)                     who = m_own;
      else if (m_cnt >= LIMIT && i_rd_req) who = 1;
      else if (dreq)                      who = 2;
      else if (i_rd_req)                  who = 1;
      else                                who = 0;
      wants     = (who == 1) ? i_rd_req : (who == 2) ? dreq : 1'b0;
      completes = wants && !rw_wait;
      if (wants && rw_wait)               nxt_own = who;
      else if (who == 2 && completes && d_lock) nxt_own = 2;
      else                                nxt_own = 0;
      if (!i_rd_req || (who == 1 && !rw_wait)) nxt_cnt = 0;
      else if (who != 1)                  nxt_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else                                nxt_cnt = m_cnt;
    end

    check({tag, ".owner"}, 32'(owner), 32'(who));
    check({tag, ".rd_req"}, 32'(rd_req),
          32'((who == 1) ? i_rd_req : (who == 2) ? d_rd_req : 1'b0));
    check({tag, ".wr_req"}, 32'(wr_req), 32'((who == 2) ? d_wr_req : 1'b0));
    check({tag, ".i_wait"}, 32'(i_wait),
          32'(Nrst ? 1'b1 : (who == 1) ? rw_wait : i_rd_req));
    check({tag, ".d_wait"}, 32'(d_wait),
          32'(Nrst ? 1'b1 : (who == 2) ? rw_wait : dreq));
    check({tag, ".i_rd_data"}, i_rd_data, rd_data);
    check({tag, ".d_rd_data"}, d_rd_data, rd_data);
    if (who == 1) begin
      check({tag, ".busaddr"}, busaddr, i_addr);
      check({tag, ".size"}, 32'(data_size), 32'(3'b100));
    end else if (who == 2) begin
      check({tag, ".busaddr"}, busaddr, d_addr);
      check({tag, ".size"}, 32'(data_size), 32'(d_size));
      check({tag, ".wr_data"}, wr_data, d_wr_data);
    end

    s_owner   = owner;
    s_wr_req  = wr_req;
    s_wr_data = wr_data;
    s_busaddr = busaddr;
    s_rd_req  = rd_req;
    s_i_wait  = i_wait;
    s_d_wait  = d_wait;

    @(posedge clk);
    m_own = nxt_own;
    m_cnt = nxt_cnt;
    #1;
  endtask

  task automatic quiet();
    Nrst = 0; i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; d_lock = 0; rw_wait = 0;
  endtask

  initial begin
    Nrst = 1; i_addr = 0; i_rd_req = 0; d_addr = 0; d_rd_req = 0; d_wr_req = 0;
    d_wr_data = 0; d_size = 3'b100; d_lock = 0; rw_wait = 0; rd_data = 32'h1234_5678;

    // Reset with both masters asking: no bus request, both stalled.
    i_rd_req = 1; d_rd_req = 1;
    cycle("rst0");
    check("rst.owner", 32'(s_owner), 32'h0);
    check("rst.i_wait", 32'(s_i_wait), 32'h1);
    cycle("rst1");
    quiet();
    cycle("idle");

    // Lone fetch, zero-wait: same-cycle grant.
    i_addr = 32'h100; i_rd_req = 1; rd_data = 32'hCAFE_0001;
    cycle("t1");
    check("t1.owner", 32'(s_owner), 32'h1);
    check("t1.busaddr", s_busaddr, 32'h100);
    check("t1.i_wait", 32'(s_i_wait), 32'h0);
    check("t1.d_wait", 32'(s_d_wait), 32'h0);
    quiet();
    cycle("t1_gap");

    // Both ask; D wins and holds for three cycles, then I is granted.
    i_rd_req = 1; i_addr = 32'h104;
    d_rd_req = 1; d_addr = 32'h2000; d_size = 3'b100;
    for (int k = 0; k < 3; k++) begin
      rw_wait = (k < 2);
      cycle($sformatf("t2_%0d", k));
      check("t2.owner_d", 32'(s_owner), 32'h2);
      check("t2.i_wait", 32'(s_i_wait), 32'h1);
    end
    d_rd_req = 0; rw_wait = 0;
    cycle("t2_igrant");
    check("t2.owner_i", 32'(s_owner), 32'h1);
    quiet();
    cycle("t2_gap");

    // SWP: locked read then write, fetch asking throughout.
    i_rd_req = 1;
    d_rd_req = 1; d_addr = 32'h3000; d_lock = 1; rw_wait = 0;
    cycle("swp_rd");
    check("swp_rd.owner", 32'(s_owner), 32'h2);
    d_rd_req = 0; d_wr_req = 1; d_wr_data = 32'hAABB_CCDD; d_lock = 0;
    cycle("swp_wr");
    check("swp_wr.owner", 32'(s_owner), 32'h2);
    check("swp_wr.wr_req", 32'(s_wr_req), 32'h1);
    check("swp_wr.wr_data", s_wr_data, 32'hAABB_CCDD);
    d_wr_req = 0;
    cycle("swp_i");
    check("swp_i.owner", 32'(s_owner), 32'h1);
    quiet();
    cycle("swp_gap");

    // Starvation: D back-to-back with one wait each; I forced in on the 9th.
    i_rd_req = 1; i_addr = 32'h200; d_rd_req = 1; d_addr = 32'h4000;
    for (int k = 0; k < 8; k++) begin
      rw_wait = (k % 2 == 0);
      cycle($sformatf("starve_%0d", k));
      check("starve.owner_d", 32'(s_owner), 32'h2);
    end
    rw_wait = 0;
    cycle("starve_win");
    check("starve.owner_i", 32'(s_owner), 32'h1);
    rw_wait = 1;
    cycle("starve_clr");
    check("starve.cleared", 32'(s_owner), 32'h2);
    rw_wait = 0;
    cycle("starve_end");
    quiet();
    cycle("starve_gap");

    // Reset while D owns the bus with a wait pending.
    d_rd_req = 1; d_addr = 32'h5000; rw_wait = 1;
    cycle("rstmid_own");
    Nrst = 1;
    cycle("rstmid_0");
    check("rstmid.owner", 32'(s_owner), 32'h0);
    check("rstmid.rd_req", 32'(s_rd_req), 32'h0);
    check("rstmid.d_wait", 32'(s_d_wait), 32'h1);
    cycle("rstmid_1");
    quiet();
    cycle("rstmid_gap");

    // Owner drops its request mid-wait; D takes the bus next cycle.
    i_rd_req = 1; i_addr = 32'h300; rw_wait = 1;
    cycle("drop_own");
    i_rd_req = 0; d_rd_req = 1; d_addr = 32'h6000;
    cycle("drop_rel");
    check("drop.no_req", 32'(s_rd_req), 32'h0);
    rw_wait = 0;
    cycle("drop_d");
    check("drop.owner_d", 32'(s_owner), 32'h2);
    quiet();
    cycle("drop_gap");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      Nrst      = ($urandom_range(0, 49) == 0);
      i_rd_req  = ($urandom_range(0, 2) != 0);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wr_data = $urandom;
      rd_data   = $urandom;
      case ($urandom_range(0, 2))
        0: begin d_rd_req = 1; d_wr_req = 0; end
        1: begin d_rd_req = 0; d_wr_req = 1; end
        default: begin d_rd_req = 0; d_wr_req = 0; end
      endcase
      case ($urandom_range(0, 2))
        0: d_size = 3'b001;
        1: d_size = 3'b010;
        default: d_size = 3'b100;
      endcase
      d_lock  = ($urandom_range(0, 3) == 0);
      rw_wait = ($urandom_range(0, 1) == 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_bus_arbiter
